bus_drive_ctrl: RTL and testbench
=================================

# bus_drive_ctrl

Half-duplex shared-bus controller that sits directly upstream of the tri-state driver stage and generates its data (`bus_out`) and `enable` (`bus_en`). It accepts local words over a valid/ready handshake and arbitrates bus ownership with one peer via request/grant. It enforces idle turnaround cycles between owners and captures peer-driven words from the resolved bus.

## Interface
- `WIDTH`, 8: bus data width.
- `TURN`, 2: idle turnaround cycles after every ownership period; legal range ≥1.
- `BURST_MAX`, 4: maximum local words per ownership period; legal range ≥1.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `tx_data` input WIDTH: local word to drive.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: combinational; high = word accepted this cycle if `tx_valid`.
- `bus_out` output WIDTH: registered; feeds tri-state data input.
- `bus_en` output 1: registered; feeds tri-state enable.
- `bus_in` input WIDTH: resolved bus value read back.
- `peer_req` input 1: peer requests bus ownership.
- `peer_gnt` output 1: registered; peer may drive the bus.
- `peer_strobe` input 1: peer marks a valid word on the bus.
- `rx_data` output WIDTH: registered captured peer word.
- `rx_valid` output 1: registered one-cycle pulse with `rx_data`.
- `bus_err` output 1: sticky contention flag (see Configuration).

## Operation
- Reset values: state IDLE, `bus_out`=0, `bus_en`=0, `peer_gnt`=0, `rx_data`=0, `rx_valid`=0, `bus_err`=0, burst count=0, last_owner=PEER.
- States: IDLE, DRIVE, PEER, GAP.
- IDLE:
  - `tx_valid` only → DRIVE.
  - `peer_req` only → PEER.
  - Both asserted → grant goes to the side opposite last_owner. After reset, local wins.
  - On entry to DRIVE or PEER, last_owner is updated; burst count is cleared on DRIVE entry.
- DRIVE:
  - `tx_ready` = (state==DRIVE && count<BURST_MAX).
  - Handshake: `bus_out`<=`tx_data`, count++.
  - `bus_en`<= handshake, so `bus_en` is high exactly one cycle per accepted word.
  - No handshake: `bus_out` holds its value.
  - Exit to GAP in any DRIVE cycle with no handshake, i.e. `tx_valid`=0 or count==BURST_MAX.
- PEER:
  - `peer_gnt`=1. Local `bus_en` is forced 0 and `tx_ready`=0.
  - `peer_strobe` → `rx_data`<=`bus_in`, `rx_valid`<=1.
  - `peer_req`=0 → GAP; `peer_gnt` drops on the same edge.
- GAP: `bus_en`=0 and `peer_gnt`=0 for exactly TURN cycles, then IDLE.
- `rx_valid` is 0 in all cycles other than the capture cycle.
- Reset asserted mid-burst or mid-PEER: all state returns to reset values on that edge. The pending word is discarded and there is no GAP.

## Timing
- Local word latency: handshake at edge N → `bus_out`/`bus_en` valid for cycle N+1.
- Start-up: `tx_valid` in IDLE at cycle C → DRIVE at C+1 (`tx_ready` high) → first word on bus at C+2.
- Streaming: back-to-back handshakes give back-to-back bus words; max throughput is 1 word/cycle, up to BURST_MAX words.
- Release: DRIVE exit occurs only in a no-handshake cycle, so `bus_en` is already 0 in every GAP cycle.
  - Minimum bus-idle between the last local word and `peer_gnt` = TURN+1 cycles.
  - `peer_gnt` to local `bus_en` = TURN+2 cycles.
- Peer capture: `peer_strobe` at cycle P → `rx_valid`/`rx_data` at P+1.
- Contention mid-PEER (`tx_valid` rising) is ignored until IDLE.

## Configuration
- `BUS_CHECK_EN` defined: in every cycle with `bus_en`=1, if `bus_in`≠`bus_out`, `bus_err` is set on the next edge. The flag is sticky and cleared only by `reset`.
- `BUS_CHECK_EN` undefined: the compare logic is absent and `bus_err` is constant 0. The port remains present.

## Test plan
- Reset then 3 words 0x11,0x22,0x33 with `tx_valid` held, WIDTH=8:
  - `bus_en` high cycles C+2..C+4 carrying those values.
  - GAP of 2 cycles, then IDLE.
- 6 words offered, BURST_MAX=4, `peer_req`=1 from the 2nd word:
  - 4 words driven, `tx_ready` low.
  - `peer_gnt` rises exactly TURN+1 cycles after the last `bus_en`.
  - Remaining 2 words are sent only after `peer_req` drops and the GAP completes.
- Simultaneous `tx_valid` and `peer_req` in IDLE after reset:
  - Local wins first.
  - On the next simultaneous request, peer wins.
- In PEER, `peer_strobe` with `bus_in`=0xA5 → `rx_valid` pulse of one cycle with `rx_data`=0xA5. No `rx_valid` without strobe.
- `reset` asserted while `bus_en`=1 mid-burst → next cycle `bus_en`=0, `tx_ready`=0, state IDLE.
- With `BUS_CHECK_EN`:
  - Force `bus_in`=0x00 while driving 0xFF → `bus_err`=1 next cycle, held until reset.
  - Without the macro, `bus_err` stays 0.

Source files
------------

// File: rtl/bus_drive_ctrl.sv
// bus_drive_ctrl: half-duplex shared-bus controller feeding a tri-state driver stage
// Ports: clk/reset (sync, active-high); tx_data/tx_valid/tx_ready local word handshake;
// bus_out/bus_en registered tri-state data/enable; bus_in resolved bus read-back;
// peer_req/peer_gnt ownership arbitration; peer_strobe/rx_data/rx_valid peer word capture;
// bus_err sticky contention flag, live only when BUS_CHECK_EN is defined.
module bus_drive_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TURN      = 2,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             peer_req,
  output logic             peer_gnt,
  input  logic             peer_strobe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             bus_err
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int GW = $clog2(TURN + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(BURST_MAX);
  localparam logic [GW-1:0] G_LAST = GW'(TURN - 1);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_PEER, S_GAP} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [GW-1:0]   r_gap;
  logic            r_last_peer;
  logic            w_hs;
  logic            w_local_win;
  assign tx_ready    = (r_state == S_DRIVE) && (r_count < C_MAX);
  assign w_hs        = tx_valid && tx_ready;
  // on a tie the side that did not own the bus last time wins
  assign w_local_win = tx_valid && (!peer_req || r_last_peer);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_gap       <= '0;
      r_last_peer <= 1'b1;
      bus_out     <= '0;
      bus_en      <= 1'b0;
      peer_gnt    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      bus_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_local_win) begin
            r_state     <= S_DRIVE;
            r_last_peer <= 1'b0;
            r_count     <= '0;
          end else if (peer_req) begin
            r_state     <= S_PEER;
            r_last_peer <= 1'b1;
            peer_gnt    <= 1'b1;
          end
        end
        S_DRIVE: begin
          // leaving only on a no-handshake cycle guarantees bus_en is already low in GAP
          if (w_hs) begin
            bus_out <= tx_data;
            bus_en  <= 1'b1;
            r_count <= r_count + CW'(1);
          end else begin
            r_state <= S_GAP;
            r_gap   <= '0;
          end
        end
        S_PEER: begin
          if (peer_strobe) begin
            rx_data  <= bus_in;
            rx_valid <= 1'b1;
          end
          if (!peer_req) begin
            r_state  <= S_GAP;
            r_gap    <= '0;
            peer_gnt <= 1'b0;
          end
        end
        default: begin
          if (r_gap == G_LAST) r_state <= S_IDLE;
          else r_gap <= r_gap + GW'(1);
        end
      endcase
    end
  end
`ifdef BUS_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) bus_err <= 1'b0;
    else if (bus_en && (bus_in != bus_out)) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_drive_ctrl.sv
// tb_bus_drive_ctrl: directed-plus-random bench for bus_drive_ctrl against an event-level model
module tb_bus_drive_ctrl;
  localparam int W    = 8;
  localparam int TURN = 2;
  localparam int BM   = 4;
`ifdef BUS_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  logic         clk = 1'b0, reset = 1'b1, tx_valid = 1'b0, peer_req = 1'b0, peer_strobe = 1'b0;
  logic         force_bad = 1'b0, gnt_d = 1'b0;
  logic         tx_ready, bus_en, peer_gnt, rx_valid, bus_err;
  logic [W-1:0] tx_data = '0, peer_bus = '0;
  logic [W-1:0] bus_out, bus_in, rx_data;
  int           cyc = 0, n_chk = 0, n_pass = 0, n_fail = 0, pr_on = 0, pr_off = 0;
  logic [63:0]  got_q[$], exp_q[$];
  logic [7:0]   txq[$], mw[$];

  bus_drive_ctrl #(.WIDTH(W), .TURN(TURN), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_out(bus_out), .bus_en(bus_en), .bus_in(bus_in), .peer_req(peer_req),
    .peer_gnt(peer_gnt), .peer_strobe(peer_strobe), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus_err(bus_err)
  );

  // resolved bus: our driver when enabled, otherwise the peer's value; force_bad models contention
  assign bus_in = force_bad ? '0 : (bus_en ? bus_out : peer_bus);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event codes: 1 bus word, 2 tx_ready cycle, 3 grant rise, 4 rx capture, 5 grant fall
  function automatic logic [63:0] ev(input int k, input int c, input int v);
    ev = {k[7:0], c[31:0], v[23:0]};
  endfunction

  always @(negedge clk) begin
    if (bus_en) got_q.push_back(ev(1, cyc, int'(bus_out)));
    if (tx_ready) got_q.push_back(ev(2, cyc, 0));
    if (peer_gnt && !gnt_d) got_q.push_back(ev(3, cyc, 0));
    if (rx_valid) got_q.push_back(ev(4, cyc, int'(rx_data)));
    if (!peer_gnt && gnt_d) got_q.push_back(ev(5, cyc, 0));
    gnt_d = peer_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare(input string tag);
    got_q.sort();
    exp_q.sort();
    chk($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // words in mw offered back-to-back with no peer, first DRIVE cycle s:
  // bursts of up to BM words, each burst exit followed by TURN gap cycles, one IDLE, then DRIVE
  task automatic exp_stream(input int s0);
    int s = s0;
    int i = 0;
    int k;
    while (i < mw.size()) begin
      k = (mw.size() - i < BM) ? mw.size() - i : BM;
      for (int j = 0; j < k; j++) begin
        exp_q.push_back(ev(1, s + 1 + j, int'(mw[i+j])));
        exp_q.push_back(ev(2, s + j, 0));
      end
      if (k < BM) exp_q.push_back(ev(2, s + k, 0));
      i += k;
      s += k + TURN + 2;
    end
  endtask

  task automatic drain(input int budget);
    logic hs;
    int t = 0;
    while (txq.size() > 0 && t < budget) begin
      tx_valid = 1'b1;
      tx_data  = txq[0];
      peer_req = (cyc >= pr_on) && (cyc < pr_off);
      hs = tx_ready;
      tick();
      t++;
      if (hs) void'(txq.pop_front());
    end
    tx_valid = 1'b0;
    peer_req = 1'b0;
    chk("drain_done", 64'(txq.size()), 64'd0);
    txq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, p, n;
    logic [7:0] w0, w1, w2;
    tick();
    tick();
    chk("rst_bus_en", 64'(bus_en), 64'd0);
    chk("rst_bus_out", 64'(bus_out), 64'd0);
    chk("rst_peer_gnt", 64'(peer_gnt), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    reset = 1'b0;
    tick();
    got_q.delete();

    // three words then a fourth after release: GAP of TURN cycles before re-entry
    c = cyc;
    txq = '{8'h11, 8'h22, 8'h33};
    mw  = '{8'h11, 8'h22, 8'h33};
    exp_stream(c + 1);
    drain(50);
    tick();
    chk("s1_gap_ready", 64'(tx_ready), 64'd0);
    txq = '{8'h44};
    mw  = '{8'h44};
    exp_stream(c + 8);
    drain(50);
    repeat (4) tick();
    compare("s1");

    // six words, peer requests from the second; peer owns after burst of BM and TURN+1 idle cycles
    c = cyc;
    for (int i = 0; i < 6; i++) txq.push_back(8'($urandom));
    mw = txq;
    pr_on  = c + 2;
    pr_off = c + 12;
    for (int j = 0; j < BM; j++) begin
      exp_q.push_back(ev(1, c + 2 + j, int'(mw[j])));
      exp_q.push_back(ev(2, c + 1 + j, 0));
    end
    exp_q.push_back(ev(3, c + 5 + TURN + 2, 0));
    exp_q.push_back(ev(5, c + 13, 0));
    for (int j = 0; j < 2; j++) exp_q.push_back(ev(1, c + 13 + TURN + 2 + j, int'(mw[BM+j])));
    for (int j = 0; j < 3; j++) exp_q.push_back(ev(2, c + 13 + TURN + 1 + j, 0));
    drain(100);
    repeat (4) tick();
    compare("s2");

    // simultaneous requests after reset: local first, then peer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got_q.delete();
    c = cyc;
    w0 = 8'($urandom);
    txq = '{w0};
    pr_on  = c;
    pr_off = c + 1;
    exp_q.push_back(ev(1, c + 2, int'(w0)));
    exp_q.push_back(ev(2, c + 1, 0));
    exp_q.push_back(ev(2, c + 2, 0));
    drain(50);
    repeat (3) tick();
    d = cyc;
    w1 = 8'($urandom);
    txq = '{w1};
    pr_on  = d;
    pr_off = d + 3;
    exp_q.push_back(ev(3, d + 1, 0));
    exp_q.push_back(ev(5, d + 4, 0));
    exp_q.push_back(ev(2, d + 7, 0));
    exp_q.push_back(ev(2, d + 8, 0));
    exp_q.push_back(ev(1, d + 8, int'(w1)));
    drain(50);
    repeat (4) tick();
    compare("s3");

    // peer ownership with random strobes; capture only while granted
    p = cyc;
    exp_q.push_back(ev(3, p + 1, 0));
    exp_q.push_back(ev(5, p + 12, 0));
    for (int t = 0; t < 14; t++) begin
      peer_req    = (t < 11);
      peer_strobe = (t == 3) ? 1'b1 : (t == 4) ? 1'b0 : 1'($urandom_range(0, 1));
      peer_bus    = (t == 3) ? 8'hA5 : 8'($urandom);
      if (t >= 1 && t <= 11 && peer_strobe) exp_q.push_back(ev(4, p + t + 1, int'(peer_bus)));
      if (t == 4) begin
        chk("s4_rx_valid_pulse", 64'(rx_valid), 64'd1);
        chk("s4_rx_data", 64'(rx_data), 64'hA5);
      end
      if (t == 5) chk("s4_rx_valid_drop", 64'(rx_valid), 64'd0);
      tick();
    end
    peer_req = 1'b0;
    peer_strobe = 1'b0;
    compare("s4");

    // reset while a word is on the bus
    c = cyc;
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    tx_valid = 1'b1;
    tx_data  = w0;
    tick();
    tick();
    chk("s5_pre_bus_en", 64'(bus_en), 64'd1);
    tx_data = w1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_valid = 1'b0;
    chk("s5_bus_en", 64'(bus_en), 64'd0);
    chk("s5_tx_ready", 64'(tx_ready), 64'd0);
    chk("s5_bus_out", 64'(bus_out), 64'd0);
    chk("s5_peer_gnt", 64'(peer_gnt), 64'd0);
    exp_q.push_back(ev(1, c + 2, int'(w0)));
    exp_q.push_back(ev(2, c + 1, 0));
    exp_q.push_back(ev(2, c + 2, 0));
    txq = '{w1, w2};
    mw  = '{w1, w2};
    exp_stream(c + 4);
    drain(50);
    repeat (4) tick();
    compare("s5");

    // random-length local streams spanning several bursts
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 9);
      txq.delete();
      for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
      mw = txq;
      c = cyc;
      exp_stream(c + 1);
      drain(200);
      repeat (4) tick();
      compare($sformatf("rnd%0d", r));
    end

    // contention: bus reads back 0x00 while driving 0xFF
    chk("s6_err_before", 64'(bus_err), 64'd0);
    force_bad = 1'b1;
    c = cyc;
    txq = '{8'hFF};
    exp_q.push_back(ev(1, c + 2, 8'hFF));
    exp_q.push_back(ev(2, c + 1, 0));
    exp_q.push_back(ev(2, c + 2, 0));
    drain(50);
    tick();
    chk("s6_err_set", 64'(bus_err), 64'(ERR_EXP));
    force_bad = 1'b0;
    repeat (3) tick();
    chk("s6_err_sticky", 64'(bus_err), 64'(ERR_EXP));
    compare("s6");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_err_cleared", 64'(bus_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
